cpu_sequencer: RTL and testbench

Load-and-run controller for the tiny CPU core. It accepts a program image as a byte stream over a valid/ready handshake and writes it into program memory through the core's byte write port (write enable, address, 8-bit data). It then holds the core's reset low for exactly a requested number of cycles and re-asserts it, reporting completion. It sits between the chip I/O and the core's `rst`, `pmWrEn`, `pmAddr` and `instructionIn` inputs.

---
 rtl/cpu_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Load-and-run controller: streams a program image into the core's program memory,
// then releases the core's reset for a requested cycle count. Optional macro: CPU_SEQ_CHECKSUM_EN.
module cpu_sequencer #(
   parameter int ADDWIDTH = 7,
   parameter int CYCWIDTH = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load_start,
   input  logic [ADDWIDTH:0]   load_len,
   input  logic [7:0]          byte_in,
   input  logic                byte_valid,
   output logic                byte_ready,
   input  logic                run_start,
   input  logic [CYCWIDTH-1:0] run_cycles,
   input  logic                abort,
   output logic                pm_wr_en,
   output logic [ADDWIDTH-1:0] pm_addr,
   output logic [7:0]          pm_wr_data,
   output logic                cpu_rst,
   output logic [1:0]          state,
   output logic                done,
   output logic [CYCWIDTH-1:0] cycles_run,
   output logic                err
);

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DONE = 2'd3} seqState_t;

   localparam logic [ADDWIDTH:0]   CAPACITY = {1'b1, {ADDWIDTH{1'b0}}};
   localparam logic [ADDWIDTH:0]   IDX_ONE  = {{ADDWIDTH{1'b0}}, 1'b1};
   localparam logic [CYCWIDTH-1:0] CYC_ONE  = {{(CYCWIDTH-1){1'b0}}, 1'b1};

   seqState_t           state_q, state_d;
   logic [ADDWIDTH:0]   len_q, len_d;
   logic [ADDWIDTH:0]   idx_q, idx_d;
   logic [ADDWIDTH:0]   idxNext;
   logic                wrEn_q, wrEn_d;
   logic [ADDWIDTH-1:0] addr_q, addr_d;
   logic [7:0]          data_q, data_d;
   logic                cpuRst_q, cpuRst_d;
   logic [CYCWIDTH-1:0] cycles_q, cycles_d;
   logic [CYCWIDTH-1:0] target_q, target_d;
   logic                runBlocked;

`ifdef CPU_SEQ_CHECKSUM_EN
   logic                err_q, err_d;
   logic [7:0]          sum_q, sum_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
         sum_q <= '0;
      end else begin
         err_q <= err_d;
         sum_q <= sum_d;
      end
   end

   assign runBlocked = err_q;
`else
   assign runBlocked = 1'b0;
`endif

   // State register and all datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         len_q    <= '0;
         idx_q    <= '0;
         wrEn_q   <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         cpuRst_q <= 1'b1;
         cycles_q <= '0;
         target_q <= '0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         idx_q    <= idx_d;
         wrEn_q   <= wrEn_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         cpuRst_q <= cpuRst_d;
         cycles_q <= cycles_d;
         target_q <= target_d;
      end
   end

   // Next-state logic; abort outranks byte acceptance and run completion.
   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      idx_d    = idx_q;
      wrEn_d   = 1'b0;
      addr_d   = addr_q;
      data_d   = data_q;
      cpuRst_d = cpuRst_q;
      cycles_d = cycles_q;
      target_d = target_q;
      idxNext  = idx_q + IDX_ONE;
`ifdef CPU_SEQ_CHECKSUM_EN
      err_d    = err_q;
      sum_d    = sum_q;
`endif
      unique case (state_q)
         IDLE, DONE: begin
            cpuRst_d = 1'b1;
            if (load_start && (load_len != '0)) begin
               state_d = LOAD;
               len_d   = (load_len > CAPACITY) ? CAPACITY : load_len;
               idx_d   = '0;
`ifdef CPU_SEQ_CHECKSUM_EN
               err_d   = 1'b0;
               sum_d   = '0;
`endif
            end else if (run_start && !runBlocked) begin
               cycles_d = '0;
               if (run_cycles != '0) begin
                  state_d  = RUN;
                  target_d = run_cycles;
                  cpuRst_d = 1'b0;
               end else begin
                  state_d = DONE;
               end
            end
         end
         LOAD: begin
            if (abort) begin
               state_d = IDLE;
            end else if (byte_valid) begin
`ifdef CPU_SEQ_CHECKSUM_EN
               // The byte after the last program byte is the checksum, never written.
               if (idx_q == len_q) begin
                  state_d = IDLE;
                  err_d   = (byte_in != sum_q);
               end else begin
                  wrEn_d = 1'b1;
                  addr_d = idx_q[ADDWIDTH-1:0];
                  data_d = byte_in;
                  idx_d  = idxNext;
                  sum_d  = sum_q + byte_in;
               end
`else
               wrEn_d = 1'b1;
               addr_d = idx_q[ADDWIDTH-1:0];
               data_d = byte_in;
               idx_d  = idxNext;
               if (idxNext == len_q) begin
                  state_d = IDLE;
               end
`endif
            end
         end
         RUN: begin
            if (abort) begin
               state_d  = IDLE;
               cpuRst_d = 1'b1;
            end else begin
               cycles_d = cycles_q + CYC_ONE;
               if (cycles_d == target_q) begin
                  state_d  = DONE;
                  cpuRst_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output decode.
   always_comb begin
      state      = state_q;
      byte_ready = (state_q == LOAD);
      done       = (state_q == DONE);
      pm_wr_en   = wrEn_q;
      pm_addr    = addr_q;
      pm_wr_data = data_q;
      cpu_rst    = cpuRst_q;
      cycles_run = cycles_q;
`ifdef CPU_SEQ_CHECKSUM_EN
      err        = err_q;
`else
      err        = 1'b0;
`endif
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed plan steps plus randomized loads and runs
// checked against the byte stream and cycle counts the bench itself chose.
module tb_cpu_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_start;
   logic [7:0]  load_len;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic        run_start;
   logic [15:0] run_cycles;
   logic        abort;
   logic        pm_wr_en;
   logic [6:0]  pm_addr;
   logic [7:0]  pm_wr_data;
   logic        cpu_rst;
   logic [1:0]  state;
   logic        done;
   logic [15:0] cycles_run;
   logic        err;

`ifdef CPU_SEQ_CHECKSUM_EN
   localparam bit CS_EN = 1'b1;
`else
   localparam bit CS_EN = 1'b0;
`endif

   int testCount = 0;
   int failCount = 0;
   int wrCount   = 0;
   int lowCount  = 0;
   logic [7:0] progBytes [0:255];

   cpu_sequencer dut (
      .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
      .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
      .run_start(run_start), .run_cycles(run_cycles), .abort(abort),
      .pm_wr_en(pm_wr_en), .pm_addr(pm_addr), .pm_wr_data(pm_wr_data),
      .cpu_rst(cpu_rst), .state(state), .done(done), .cycles_run(cycles_run), .err(err)
   );

   always #5 clk = ~clk;

   // Tally write pulses and reset-low cycles as the core would see them.
   always @(negedge clk) begin
      if (pm_wr_en === 1'b1) wrCount++;
      if (cpu_rst === 1'b0) lowCount++;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of control strobes, then drop them.
   task automatic applyStimulus(input bit ls, input int len, input bit rs, input int cyc, input bit ab);
      load_start = ls;
      load_len   = 8'(len);
      run_start  = rs;
      run_cycles = 16'(cyc);
      abort      = ab;
      @(negedge clk);
      load_start = 1'b0;
      run_start  = 1'b0;
      abort      = 1'b0;
   endtask

   task automatic sendByte(input int i, input bit lastByte);
      byte_valid = 1'b1;
      byte_in    = progBytes[i];
      @(negedge clk);
      byte_valid = 1'b0;
      checkOutput("wrEn", 32'(pm_wr_en), 32'd1);
      checkOutput("wrAddr", 32'(pm_addr), 32'(i));
      checkOutput("wrData", 32'(pm_wr_data), 32'(progBytes[i]));
      checkOutput("loadState", 32'(state), lastByte ? 32'd0 : 32'd1);
   endtask

   task automatic sendProgram(input int n, input bit gap, input int csDelta);
      logic [7:0] sum;
      sum = '0;
      for (int i = 0; i < n; i++) begin
         sum = sum + progBytes[i];
         sendByte(i, (i == n - 1) && !CS_EN);
         if (gap) begin
            @(negedge clk);
            checkOutput("gapNoWr", 32'(pm_wr_en), 32'd0);
            checkOutput("addrHold", 32'(pm_addr), 32'(i));
         end
      end
      if (CS_EN) begin
         byte_valid = 1'b1;
         byte_in    = sum + 8'(csDelta);
         @(negedge clk);
         byte_valid = 1'b0;
         checkOutput("csNoWr", 32'(pm_wr_en), 32'd0);
         checkOutput("csState", 32'(state), 32'd0);
         checkOutput("csErr", 32'(err), (csDelta != 0) ? 32'd1 : 32'd0);
      end else begin
         checkOutput("errZero", 32'(err), 32'd0);
      end
   endtask

   task automatic runCore(input int cyc);
      int lowBase;
      lowBase = lowCount;
      applyStimulus(1'b0, 0, 1'b1, cyc, 1'b0);
      if (cyc > 0) begin
         checkOutput("runState", 32'(state), 32'd2);
         checkOutput("runRstLow", 32'(cpu_rst), 32'd0);
      end
      for (int k = 0; k < cyc + 4 && state !== 2'd3; k++) @(negedge clk);
      checkOutput("doneState", 32'(state), 32'd3);
      checkOutput("doneFlag", 32'(done), 32'd1);
      checkOutput("cyclesRun", 32'(cycles_run), 32'(cyc));
      checkOutput("doneRst", 32'(cpu_rst), 32'd1);
      checkOutput("rstLowCycles", 32'(lowCount - lowBase), 32'(cyc));
   endtask

   initial begin
      int wrBase;
      int n;
      rst = 1'b1; load_start = 1'b0; load_len = '0; byte_in = '0; byte_valid = 1'b0;
      run_start = 1'b0; run_cycles = '0; abort = 1'b0;

      // Reset and idle
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("rstState", 32'(state), 32'd0);
      checkOutput("rstCpuRst", 32'(cpu_rst), 32'd1);
      checkOutput("rstWrEn", 32'(pm_wr_en), 32'd0);
      checkOutput("rstAddr", 32'(pm_addr), 32'd0);
      checkOutput("rstData", 32'(pm_wr_data), 32'd0);
      checkOutput("rstReady", 32'(byte_ready), 32'd0);
      checkOutput("rstDone", 32'(done), 32'd0);
      checkOutput("rstCycles", 32'(cycles_run), 32'd0);
      checkOutput("rstErr", 32'(err), 32'd0);

      // Load with gaps between bytes
      progBytes[0] = 8'h13; progBytes[1] = 8'h05; progBytes[2] = 8'hA0; progBytes[3] = 8'hFF;
      wrBase = wrCount;
      applyStimulus(1'b1, 4, 1'b0, 0, 1'b0);
      checkOutput("loadEnter", 32'(state), 32'd1);
      checkOutput("readyInLoad", 32'(byte_ready), 32'd1);
      sendProgram(4, 1'b1, 0);
      repeat (2) @(negedge clk);
      checkOutput("gapLoadWrites", 32'(wrCount - wrBase), 32'd4);

      // Runs
      runCore(10);
      runCore(0);
      applyStimulus(1'b0, 0, 1'b0, 0, 1'b1);
      checkOutput("abortIgnoredDone", 32'(state), 32'd3);

      // Abort during run at cycle 3 of 8
      applyStimulus(1'b0, 0, 1'b1, 8, 1'b0);
      for (int k = 0; k < 10 && cycles_run !== 16'd3; k++) @(negedge clk);
      applyStimulus(1'b0, 0, 1'b0, 0, 1'b1);
      checkOutput("abortRunState", 32'(state), 32'd0);
      checkOutput("abortRunRst", 32'(cpu_rst), 32'd1);
      checkOutput("abortRunCycles", 32'(cycles_run), 32'd3);
      checkOutput("abortRunDone", 32'(done), 32'd0);
      repeat (3) @(negedge clk);
      checkOutput("abortCyclesHold", 32'(cycles_run), 32'd3);

      // Abort during load after 2 of 5 bytes, with a byte offered on the abort edge
      for (int i = 0; i < 5; i++) progBytes[i] = 8'($urandom);
      wrBase = wrCount;
      applyStimulus(1'b1, 5, 1'b0, 0, 1'b0);
      sendByte(0, 1'b0);
      sendByte(1, 1'b0);
      byte_valid = 1'b1;
      byte_in    = progBytes[2];
      applyStimulus(1'b0, 0, 1'b0, 0, 1'b1);
      byte_valid = 1'b0;
      checkOutput("abortLoadState", 32'(state), 32'd0);
      checkOutput("abortLoadNoWr", 32'(pm_wr_en), 32'd0);
      repeat (4) @(negedge clk);
      checkOutput("abortLoadWrites", 32'(wrCount - wrBase), 32'd2);

      // Full-capacity load, then an oversized length that must clamp to capacity
      for (int i = 0; i < 128; i++) progBytes[i] = 8'($urandom);
      wrBase = wrCount;
      applyStimulus(1'b1, 128, 1'b0, 0, 1'b0);
      sendProgram(128, 1'b0, 0);
      @(negedge clk);
      checkOutput("fullLoadWrites", 32'(wrCount - wrBase), 32'd128);
      wrBase = wrCount;
      applyStimulus(1'b1, 255, 1'b0, 0, 1'b0);
      sendProgram(128, 1'b0, 0);
      @(negedge clk);
      checkOutput("clampWrites", 32'(wrCount - wrBase), 32'd128);

      // Zero-length load ignored; load wins over run in the same cycle
      applyStimulus(1'b1, 0, 1'b0, 0, 1'b0);
      checkOutput("zeroLenIgnored", 32'(state), 32'd0);
      applyStimulus(1'b1, 3, 1'b1, 5, 1'b0);
      checkOutput("loadOverRun", 32'(state), 32'd1);
      checkOutput("loadOverRunRst", 32'(cpu_rst), 32'd1);
      applyStimulus(1'b0, 0, 1'b0, 0, 1'b1);
      checkOutput("abortLoadIdle", 32'(state), 32'd0);

      // Randomized load/run transactions
      for (int r = 0; r < 6; r++) begin
         n = $urandom_range(1, 20);
         for (int i = 0; i < n; i++) progBytes[i] = 8'($urandom);
         wrBase = wrCount;
         applyStimulus(1'b1, n, 1'b0, 0, 1'b0);
         checkOutput("randLoadEnter", 32'(state), 32'd1);
         sendProgram(n, 1'($urandom_range(0, 1)), 0);
         @(negedge clk);
         checkOutput("randLoadWrites", 32'(wrCount - wrBase), 32'(n));
         runCore($urandom_range(1, 30));
      end

      // Synchronous reset in the middle of a run
      applyStimulus(1'b0, 0, 1'b1, 20, 1'b0);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("midRstState", 32'(state), 32'd0);
      checkOutput("midRstCpuRst", 32'(cpu_rst), 32'd1);
      checkOutput("midRstCycles", 32'(cycles_run), 32'd0);
      checkOutput("midRstAddr", 32'(pm_addr), 32'd0);
      checkOutput("midRstData", 32'(pm_wr_data), 32'd0);

`ifdef CPU_SEQ_CHECKSUM_EN
      // Checksum good, then bad, then run blocked, then cleared by a new load
      progBytes[0] = 8'h01; progBytes[1] = 8'h02;
      applyStimulus(1'b1, 2, 1'b0, 0, 1'b0);
      sendProgram(2, 1'b0, 0);
      applyStimulus(1'b1, 2, 1'b0, 0, 1'b0);
      sendProgram(2, 1'b0, 1);
      applyStimulus(1'b0, 0, 1'b1, 5, 1'b0);
      checkOutput("errBlocksRun", 32'(state), 32'd0);
      checkOutput("errBlocksRst", 32'(cpu_rst), 32'd1);
      applyStimulus(1'b1, 2, 1'b0, 0, 1'b0);
      checkOutput("errClearedOnLoad", 32'(err), 32'd0);
      sendProgram(2, 1'b0, 0);
      runCore(3);
`endif

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
